// File: rtl/serial_detect.sv
// serial_detect: detects the bit pattern 101011 (oldest bit first) on a serial
// input, one bit per clock, including overlapping occurrences. Also keeps the
// last six sampled bits on outData for display/debug.
//
// Handshake: none. x is sampled on every rising edge of clk while rst is high;
// there is no valid/ready qualification and no back-pressure.
module serial_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic       z,
    output logic [5:0] outData
);

    // Each state names the longest prefix of 101011 matched so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4,  // "1010"
        S5 = 3'd5,  // "10101"
        S6 = 3'd6   // "101011" -> match
    } state_t;

    // state_q is the FSM state register; checkers can bind to it by name.
    state_t     state_q, state_d;
    logic       z_q;
    logic [5:0] data_q, data_d;

    // Next-state decode; encoding 3'd7 is unused and falls back to S0.
    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S1 : S2;
            S2:      state_d = x ? S3 : S0;
            S3:      state_d = x ? S1 : S4;
            S4:      state_d = x ? S5 : S0;
            S5:      state_d = x ? S6 : S4;
            S6:      state_d = x ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    // Shift the newest bit into the history word at bit 0.
    always_comb begin
        data_d = {data_q[4:0], x};
    end

    // State, detection flag and history registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S0;
            z_q     <= 1'b0;
            data_q  <= 6'b000000;
        end else begin
            state_q <= state_d;
            z_q     <= (state_d == S6);
            data_q  <= data_d;
        end
    end

    assign z       = z_q;
    assign outData = data_q;

endmodule

// File: tb/tb_serial_detect.sv
// tb_serial_detect: directed and randomized checks of serial_detect against a
// reference model that keeps the last six bits and compares them to 101011.
module tb_serial_detect;

  logic       clk;
  logic       rst;
  logic       x;
  logic       z;
  logic [5:0] outData;

  int n_vec;
  int n_err;

  // reference model: history of the last six bits since reset, newest at [0]
  logic [5:0] hist;

  serial_detect dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .z       (z),
    .outData (outData)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison
  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // drive one edge, update the model and check both outputs after the edge
  task automatic step(input logic r, input logic b, output logic z_seen);
    rst = r;
    x   = b;
    @(posedge clk);
    #1;
    if (!r) hist = 6'b000000;
    else    hist = {hist[4:0], b};
    check("z", {5'b0, z}, {5'b0, (hist == 6'b101011)});
    check("outData", outData, hist);
    z_seen = z;
  endtask

  // feed n bits MSB first with rst high; mask[k] holds z after edge k+1
  task automatic feed(input logic [31:0] bits, input int n, output logic [31:0] mask);
    logic zs;
    mask = '0;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], zs);
      mask[n - 1 - i] = zs;
    end
  endtask

  task automatic do_reset();
    logic zs;
    step(1'b0, 1'b1, zs);
    step(1'b0, 1'b0, zs);
  endtask

  initial begin
    logic        zs;
    logic [31:0] mask;
    logic [31:0] word;
    n_vec = 0;
    n_err = 0;
    hist  = 6'b000000;
    rst   = 1'b0;
    x     = 1'b0;
    #1;

    // reset with x toggling
    do_reset();
    check("reset_z", {5'b0, z}, 6'd0);
    check("reset_out", outData, 6'b000000);

    // single match, then one more 0
    feed(32'b101011, 6, mask);
    check("single_mask", mask[5:0], 6'b100000);
    check("single_out", outData, 6'b101011);
    step(1'b1, 1'b0, zs);
    check("single_after_z", {5'b0, zs}, 6'd0);
    check("single_after_out", outData, 6'b010110);

    // overlapping matches at edges 6 and 11
    do_reset();
    feed(32'b10101101011, 11, mask);
    check("overlap_lo", mask[5:0], 6'b100000);
    check("overlap_hi", {1'b0, mask[10:6]}, 6'b010000);

    // near miss with a late match at edge 8
    do_reset();
    feed(32'b10101011, 8, mask);
    check("near1_lo", {2'b0, mask[3:0]}, 6'd0);
    check("near1_hi", {2'b0, mask[7:4]}, 6'b001000);

    // near miss with no match
    do_reset();
    feed(32'b1011100, 7, mask);
    check("near2", mask[5:0], 6'd0);
    check("near2_last", {5'b0, mask[6]}, 6'd0);

    // reset in the middle of a partial match
    do_reset();
    feed(32'b10101, 5, mask);
    step(1'b0, 1'b1, zs);
    check("midrst_out0", outData, 6'b000000);
    step(1'b1, 1'b1, zs);
    check("midrst_z", {5'b0, zs}, 6'd0);
    check("midrst_out", outData, 6'b000001);

    // rotating 25-bit word; first pass has matches at edges 8, 13, 23
    do_reset();
    word = 32'b0010101101011100010101100;
    feed(word, 25, mask);
    check("rot_m0", mask[5:0], 6'b000000);
    check("rot_m1", mask[11:6], 6'b000010);
    check("rot_m2", mask[17:12], 6'b000001);
    check("rot_m3", mask[23:18], 6'b010000);
    check("rot_m4", {5'b0, mask[24]}, 6'd0);
    feed(word, 25, mask);
    feed(word, 25, mask);

    // randomized stream with occasional resets
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), zs);
    end

    // randomized stream biased towards the pattern
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) feed(32'b101011, 6, mask);
      else feed(32'($urandom_range(0, 15)), 4, mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
